// File: rtl/pwm_multichannel_if.sv
// pwm_multichannel_if: control/status bundle for pwm_multichannel.
//   en          run enable
//   period      new period value (cycles), captured on load
//   duty        packed new duty values, channel i at [i*CNT_W +: CNT_W]
//   load        one-cycle strobe writing period/duty into the pending buffer
//   pending     buffered values are waiting for a period boundary
//   period_end  one-cycle pulse on the last cycle of each period
//   pwm         per-channel PWM outputs, active-high
// master drives the controls, slave is the PWM block.
interface pwm_multichannel_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic                    en;
  logic [CNT_W-1:0]        period;
  logic [N_CH*CNT_W-1:0]   duty;
  logic                    load;
  logic                    pending;
  logic                    period_end;
  logic [N_CH-1:0]         pwm;

  modport master (output en, period, duty, load,
                  input  pending, period_end, pwm);
  modport slave  (input  en, period, duty, load,
                  output pending, period_end, pwm);
endinterface

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N-channel PWM generator sharing one period counter.
// Period and duty writes go to a pending buffer and are promoted to the
// active registers only at a period boundary, so outputs never glitch
// mid-period.
//   cclk  system clock (rising edge)
//   rstb  asynchronous active-low reset
//   bus   pwm_multichannel_if.slave (en, period, duty, load in;
//         pending, period_end, pwm out)
// Optional build macro PWM_CENTER_EN: triangle counter
// 0..P-1,P-1..0 (2*P cycles per period), boundary on the final 0.
// Without it the counter is edge-aligned 0..P-1.

// Per-channel active duty register and compare.
module pwm_multichannel_lane #(
  parameter int CNT_W = 16
) (
  input  logic             cclk,
  input  logic             rstb,
  input  logic             apply_i,
  input  logic [CNT_W-1:0] pduty_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             run_i,
  output logic             pwm_o
);
  logic [CNT_W-1:0] duty_q;

  always_ff @(posedge cclk or negedge rstb)
    if (!rstb)        duty_q <= '0;
    else if (apply_i) duty_q <= pduty_i;

  // duty 0 never matches, duty >= period always matches
  assign pwm_o = run_i && (count_i < duty_q);
endmodule

module pwm_multichannel #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic               cclk,
  input  logic               rstb,
  pwm_multichannel_if.slave  bus
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            period_q;
  logic [CNT_W-1:0]            pper_q;
  logic [N_CH-1:0][CNT_W-1:0]  pduty_q;
  logic                        pending_q, pending_d;
  logic                        run, cnt_end, boundary, apply;
  logic [CNT_W-1:0]            pmax;
  logic [N_CH-1:0]             pwm;

  assign run  = bus.en && (period_q != '0);
  // only meaningful while run is high, so the wrap at period_q==0 is harmless
  assign pmax = period_q - ONE;

`ifdef PWM_CENTER_EN
  logic dir_q, dir_d;  // 1 = down leg

  assign cnt_end = dir_q && (count_q == '0);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    if (!run) begin
      count_d = '0;
      dir_d   = 1'b0;
    end else if (!dir_q) begin
      // peak value is held for two cycles: flip dir, keep count
      if (count_q == pmax) dir_d   = 1'b1;
      else                 count_d = count_q + ONE;
    end else begin
      if (count_q == '0)   dir_d   = 1'b0;
      else                 count_d = count_q - ONE;
    end
  end

  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) dir_q <= 1'b0;
    else       dir_q <= dir_d;
`else
  assign cnt_end = (count_q == pmax);

  always_comb begin
    count_d = count_q;
    if (!run || cnt_end) count_d = '0;
    else                 count_d = count_q + ONE;
  end
`endif

  // idle (en low or period 0) counts as a boundary so pending values land promptly
  assign boundary       = !run || cnt_end;
  assign apply          = boundary && pending_q;
  assign bus.period_end = run && cnt_end;
  assign bus.pending    = pending_q;

  // a load on the boundary cycle keeps pending set for the new buffer contents
  always_comb begin
    pending_d = pending_q;
    if (bus.load)      pending_d = 1'b1;
    else if (boundary) pending_d = 1'b0;
  end

  always_ff @(posedge cclk or negedge rstb)
    if (!rstb) begin
      count_q   <= '0;
      period_q  <= '0;
      pper_q    <= '0;
      pduty_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      if (apply) period_q <= pper_q;
      if (bus.load) begin
        pper_q  <= bus.period;
        pduty_q <= bus.duty;
      end
    end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    pwm_multichannel_lane #(.CNT_W(CNT_W)) u_lane (
      .cclk    (cclk),
      .rstb    (rstb),
      .apply_i (apply),
      .pduty_i (pduty_q[g]),
      .count_i (count_q),
      .run_i   (run),
      .pwm_o   (pwm[g])
    );
  end

  assign bus.pwm = pwm;
endmodule
